// File: rtl/deck_pool.sv
// deck_pool: UNO card store held as a stack of NUM_COLORS*27 slots.
// Provides a one-cycle standard ordered fill, an in-place Fisher-Yates
// shuffle driven by a Galois LFSR, and draw (pop) / insert (push) ports.
// Optional feature macro: DECK_POOL_BYPASS_EN (draw+insert on an empty
// stack hands the inserted card straight to the drawer instead of storing it).
//
// Handshakes: an insert transfers on a cycle where i_ins_valid && o_ins_ready
// are both high; o_ins_ready is high only in IDLE, not full, and with neither
// i_init nor i_shuffle asserted. A draw is a single-cycle request sampled in
// IDLE (no init/shuffle); the answer is a one-cycle o_draw_valid or
// o_draw_miss pulse on the following cycle. Requests outside IDLE are dropped.
module deck_pool #(
  parameter int          NUM_COLORS = 4,
  parameter int          COLOR_W    = 2,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         DECK_SIZE  = 27 * NUM_COLORS,
  localparam int         CARD_W     = COLOR_W + 4,
  localparam int         IDX_W      = $clog2(DECK_SIZE + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_init,
  input  logic                      i_shuffle,
  input  logic                      i_draw_req,
  output logic                      o_draw_valid,
  output logic                      o_draw_miss,
  output logic [CARD_W-1:0]         o_draw_card,
  input  logic                      i_ins_valid,
  output logic                      o_ins_ready,
  input  logic [CARD_W-1:0]         i_ins_card,
  output logic [IDX_W-1:0]          o_count,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_busy,
  output logic [DECK_SIZE*CARD_W-1:0] o_deck
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHUFFLE} state_t;

  state_t            state_q, state_d;
  logic [CARD_W-1:0] slot_q [DECK_SIZE];
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  k_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       free_q;

  logic              cmd_free;
  logic              ins_fire;
  logic              draw_fire;
  logic              is_full;
  logic [IDX_W-1:0]  j_idx;
  logic              swap_ok;
  logic [15:0]       lfsr_step;
  logic [15:0]       seed_val;

  // Standard ordered card for slot i: colour i/27, values 0,1,1,...,12,12,13,14.
  function automatic logic [CARD_W-1:0] init_card(input int i);
    int         c;
    int         v;
    logic [3:0] val;
    c = i / 27;
    v = i % 27;
    if (v == 0)       val = 4'd0;
    else if (v == 25) val = 4'd13;
    else if (v == 26) val = 4'd14;
    else              val = 4'((v + 1) / 2);
    return {COLOR_W'(c), val};
  endfunction

  // Shared control decode for the handshakes and the shuffle step.
  always_comb begin
    is_full   = (count_q == IDX_W'(DECK_SIZE));
    cmd_free  = (state_q == ST_IDLE) && !i_init && !i_shuffle;
    ins_fire  = cmd_free && !is_full && i_ins_valid;
    draw_fire = cmd_free && i_draw_req;
    j_idx     = lfsr_q[IDX_W-1:0];
    swap_ok   = (count_q >= IDX_W'(2)) && (j_idx <= k_q);
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    seed_val  = free_q ^ SEED;
    if (seed_val == 16'h0000) seed_val = 16'h0001;
  end

  // Next-state logic: i_init wins from every state.
  always_comb begin
    state_d = state_q;
    if (i_init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:    state_d = ST_IDLE;
        ST_IDLE:    if (i_shuffle) state_d = ST_SHUFFLE;
        ST_SHUFFLE: if ((count_q < IDX_W'(2)) || (swap_ok && (k_q == IDX_W'(1))))
                      state_d = ST_IDLE;
        default:    state_d = ST_INIT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Card storage, stack pointer, shuffle cursor and draw result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DECK_SIZE; i++) slot_q[i] <= '0;
      count_q      <= '0;
      k_q          <= '0;
      lfsr_q       <= '0;
      free_q       <= '0;
      o_draw_valid <= 1'b0;
      o_draw_miss  <= 1'b0;
      o_draw_card  <= '0;
    end else begin
      free_q       <= free_q + 16'd1;
      o_draw_valid <= 1'b0;
      o_draw_miss  <= 1'b0;
      case (state_q)
        ST_INIT: begin
          for (int i = 0; i < DECK_SIZE; i++) slot_q[i] <= init_card(i);
          count_q <= IDX_W'(DECK_SIZE);
        end
        ST_IDLE: begin
          if (!i_init && i_shuffle) begin
            k_q    <= count_q - IDX_W'(1);
            lfsr_q <= seed_val;
          end else if (draw_fire && (count_q != '0)) begin
            o_draw_valid <= 1'b1;
            o_draw_card  <= slot_q[count_q - IDX_W'(1)];
            if (ins_fire) slot_q[count_q - IDX_W'(1)] <= i_ins_card;
            else          count_q <= count_q - IDX_W'(1);
          end else if (draw_fire) begin
`ifdef DECK_POOL_BYPASS_EN
            if (ins_fire) begin
              o_draw_valid <= 1'b1;
              o_draw_card  <= i_ins_card;
            end else begin
              o_draw_miss <= 1'b1;
            end
`else
            o_draw_miss <= 1'b1;
            if (ins_fire) begin
              slot_q[0] <= i_ins_card;
              count_q   <= IDX_W'(1);
            end
`endif
          end else if (ins_fire) begin
            slot_q[count_q] <= i_ins_card;
            count_q         <= count_q + IDX_W'(1);
          end
        end
        ST_SHUFFLE: begin
          if (!i_init) begin
            lfsr_q <= lfsr_step;
            if (swap_ok) begin
              slot_q[k_q]   <= slot_q[j_idx];
              slot_q[j_idx] <= slot_q[k_q];
              k_q           <= k_q - IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs and flattened deck view, all taken straight from registers
  // except the insert ready, which must see the same-cycle init/shuffle.
  always_comb begin
    o_count     = count_q;
    o_empty     = (count_q == '0);
    o_full      = is_full;
    o_busy      = (state_q != ST_IDLE);
    o_ins_ready = cmd_free && !is_full;
    for (int i = 0; i < DECK_SIZE; i++) o_deck[i*CARD_W +: CARD_W] = slot_q[i];
  end

endmodule

// File: tb/tb_deck_pool.sv
// tb_deck_pool: directed bench for deck_pool with default parameters
// (4 colours, 108 cards, 6-bit card codes).
module tb_deck_pool;

  localparam int DS = 108;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         init, shuffle, draw_req, ins_valid;
  logic [5:0]   ins_card;
  logic         draw_valid, draw_miss, ins_ready;
  logic [5:0]   draw_card;
  logic [6:0]   count;
  logic         empty, full, busy;
  logic [DS*6-1:0] deck;

  deck_pool dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_init       (init),
    .i_shuffle    (shuffle),
    .i_draw_req   (draw_req),
    .o_draw_valid (draw_valid),
    .o_draw_miss  (draw_miss),
    .o_draw_card  (draw_card),
    .i_ins_valid  (ins_valid),
    .o_ins_ready  (ins_ready),
    .i_ins_card   (ins_card),
    .o_count      (count),
    .o_empty      (empty),
    .o_full       (full),
    .o_busy       (busy),
    .o_deck       (deck)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] val_tab [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ord_card(input int i);
    logic [1:0] c;
    c = 2'(i / 27);
    return {c, val_tab[i % 27]};
  endfunction

  function automatic logic [5:0] slot(input int i);
    return deck[i*6 +: 6];
  endfunction

  task automatic check_ordered(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < DS; i++) if (slot(i) !== ord_card(i)) bad++;
    check(name, bad, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    init = 0; shuffle = 0; draw_req = 0; ins_valid = 0; ins_card = '0;
  endtask

  task automatic reload();
    init = 1; step(); init = 0;
    check("reload_busy", busy, 1);
    step();
    check("reload_busy_done", busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       draw;
    logic       ins;
    logic [5:0] card;
    logic       e_valid;
    logic       e_miss;
    logic [5:0] e_card;
    logic [6:0] e_count;
  } vec_t;

  vec_t vt [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, changed;
    int hist_got [64];
    int hist_exp [64];

    val_tab = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5,
                4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd10, 4'd10,
                4'd11, 4'd11, 4'd12, 4'd12, 4'd13, 4'd14};

    // Starts from an empty stack with draw_card holding 6'h00.
    vt[0]  = '{0, 1, 6'h05, 0, 0, 6'h00, 7'd1};
    vt[1]  = '{0, 1, 6'h15, 0, 0, 6'h00, 7'd2};
    vt[2]  = '{0, 1, 6'h25, 0, 0, 6'h00, 7'd3};
    vt[3]  = '{1, 0, 6'h00, 1, 0, 6'h25, 7'd2};
    vt[4]  = '{1, 0, 6'h00, 1, 0, 6'h15, 7'd1};
    vt[5]  = '{1, 0, 6'h00, 1, 0, 6'h05, 7'd0};
    vt[6]  = '{1, 0, 6'h00, 0, 1, 6'h05, 7'd0};
    vt[7]  = '{0, 1, 6'h01, 0, 0, 6'h05, 7'd1};
    vt[8]  = '{0, 1, 6'h02, 0, 0, 6'h05, 7'd2};
    vt[9]  = '{0, 1, 6'h03, 0, 0, 6'h05, 7'd3};
    vt[10] = '{0, 1, 6'h04, 0, 0, 6'h05, 7'd4};
    vt[11] = '{0, 1, 6'h0A, 0, 0, 6'h05, 7'd5};
    vt[12] = '{1, 1, 6'h31, 1, 0, 6'h0A, 7'd5};
    vt[13] = '{1, 0, 6'h00, 1, 0, 6'h31, 7'd4};
    vt[14] = '{1, 0, 6'h00, 1, 0, 6'h04, 7'd3};
    vt[15] = '{1, 0, 6'h00, 1, 0, 6'h03, 7'd2};
    vt[16] = '{1, 0, 6'h00, 1, 0, 6'h02, 7'd1};
    vt[17] = '{1, 0, 6'h00, 1, 0, 6'h01, 7'd0};
`ifdef DECK_POOL_BYPASS_EN
    vt[18] = '{1, 1, 6'h31, 1, 0, 6'h31, 7'd0};
    vt[19] = '{1, 0, 6'h00, 0, 1, 6'h31, 7'd0};
`else
    vt[18] = '{1, 1, 6'h31, 0, 1, 6'h01, 7'd1};
    vt[19] = '{1, 0, 6'h00, 1, 0, 6'h31, 7'd0};
`endif

    // ---- reset state ----
    rst_n = 0;
    clear_inputs();
    step(); step();
    check("rst_busy", busy, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ins_ready", ins_ready, 0);
    check("rst_draw_valid", draw_valid, 0);
    check("rst_draw_miss", draw_miss, 0);
    check("rst_draw_card", draw_card, 0);

    // ---- power-up fill ----
    rst_n = 1;
    #1;
    check("init_busy_first", busy, 1);
    @(negedge clk);
    step();
    check("init_busy_done", busy, 0);
    check("init_count", count, DS);
    check("init_full", full, 1);
    check("init_empty", empty, 0);
    check("slot0", slot(0), 6'h00);
    check("slot26", slot(26), 6'h0E);
    check("slot27", slot(27), 6'h10);
    check("slot107", slot(107), 6'h3E);
    check_ordered("init_deck");

    // ---- draw out the whole deck ----
    for (int i = 0; i < DS; i++) begin
      draw_req = 1; step(); draw_req = 0;
      check("draw_valid", draw_valid, 1);
      check("draw_card", draw_card, ord_card(DS - 1 - i));
    end
    check("drawn_empty", empty, 1);
    check("drawn_count", count, 0);
    draw_req = 1; step(); draw_req = 0;
    check("miss_pulse", draw_miss, 1);
    check("miss_no_valid", draw_valid, 0);
    check("miss_card_held", draw_card, 6'h00);
    step();
    check("miss_one_cycle", draw_miss, 0);

    // ---- table: pushes, pops, simultaneous draw+insert ----
    for (int v = 0; v < 20; v++) begin
      draw_req = vt[v].draw; ins_valid = vt[v].ins; ins_card = vt[v].card;
      #1;
      if (vt[v].ins) check($sformatf("v%0d_ready", v), ins_ready, 1);
      @(negedge clk) ;
      clear_inputs();
      check($sformatf("v%0d_valid", v), draw_valid, vt[v].e_valid);
      check($sformatf("v%0d_miss", v), draw_miss, vt[v].e_miss);
      check($sformatf("v%0d_card", v), draw_card, vt[v].e_card);
      check($sformatf("v%0d_count", v), count, vt[v].e_count);
    end

    // ---- full: insert stalls, draw proceeds ----
    reload();
    check_ordered("reload_deck");
    draw_req = 1; ins_valid = 1; ins_card = 6'h2A;
    #1;
    check("full_ready_low", ins_ready, 0);
    @(negedge clk);
    clear_inputs();
    check("full_draw_valid", draw_valid, 1);
    check("full_draw_card", draw_card, 6'h3E);
    check("full_draw_count", count, DS - 1);
    ins_valid = 1; ins_card = 6'h2A;
    #1;
    check("refill_ready", ins_ready, 1);
    @(negedge clk);
    clear_inputs();
    check("refill_count", count, DS);
    check("refill_full", full, 1);
    check("refill_top", slot(DS - 1), 6'h2A);

    // ---- full shuffle with draws/inserts held during busy ----
    reload();
    shuffle = 1; step(); shuffle = 0;
    check("shuf_busy", busy, 1);
    draw_req = 1; ins_valid = 1; ins_card = 6'h3F;
    cyc = 0; bad = 0;
    while (busy && cyc < 5000) begin
      #1;
      if (ins_ready) bad++;
      @(negedge clk);
      if (draw_valid || draw_miss) bad++;
      cyc++;
    end
    clear_inputs();
    check("shuf_done_in_time", (cyc < 5000), 1);
    check("shuf_ignored_reqs", bad, 0);
    check("shuf_count", count, DS);
    for (int c = 0; c < 64; c++) begin hist_got[c] = 0; hist_exp[c] = 0; end
    changed = 0;
    for (int i = 0; i < DS; i++) begin
      hist_got[slot(i)]++;
      hist_exp[ord_card(i)]++;
      if (slot(i) !== ord_card(i)) changed++;
    end
    bad = 0;
    for (int c = 0; c < 64; c++) if (hist_got[c] != hist_exp[c]) bad++;
    check("shuf_histogram", bad, 0);
    check("shuf_changed", (changed > 0), 1);

    // ---- init aborts a shuffle ----
    reload();
    shuffle = 1; step(); shuffle = 0;
    for (int i = 0; i < 20; i++) step();
    check("abort_init_busy", busy, 1);
    init = 1; step(); init = 0;
    check("abort_init_state", busy, 1);
    step();
    check("abort_init_idle", busy, 0);
    check("abort_init_count", count, DS);
    check_ordered("abort_init_deck");

    // ---- reset aborts a shuffle ----
    shuffle = 1; step(); shuffle = 0;
    for (int i = 0; i < 20; i++) step();
    check("abort_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    check("abort_rst_count", count, 0);
    check("abort_rst_slot107", slot(DS - 1), 0);
    @(negedge clk);
    rst_n = 1;
    step();
    check("abort_rst_idle", busy, 0);
    check("abort_rst_full", full, 1);
    check_ordered("abort_rst_deck");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
